// File: rtl/psram_rsp.sv
// psram_rsp - octal DDR PSRAM responder (device side of the PSRAM pin interface).
//
// The block oversamples the controller's SCK with clk_i. It decodes a command
// byte and a 32-bit address on both SCK edges. It then serves burst reads,
// driving DQ and toggling DQS, or burst writes, where DQS acts as a byte mask,
// against an internal byte array.
//
// Optional feature: define PSRAM_RSP_MR_EN to add eight mode registers (MR0-MR7)
// reachable through commands 0x40 (read) and 0xC0 (write). Without it those
// commands are rejected like any other unknown command.
//
// Ports:
//   clk_i            oversampling clock (>= 4x SCK)
//   rst_n_i          asynchronous active-low reset
//   psram_sck_i      PSRAM clock from the controller, sampled as data
//   psram_ce_i       chip enable, active low
//   psram_io_in_i    DQ from the controller
//   psram_io_out_o   DQ driven back to the controller
//   psram_io_en_o    DQ output enable (all bits equal)
//   psram_dqs_in_i   write data mask (1 = byte masked)
//   psram_dqs_out_o  read strobe
//   psram_dqs_en_o   DQS output enable
//   busy_o           a transaction is in progress
//   err_o            one-cycle pulse on an unsupported command
module psram_rsp #(
    parameter int MEM_AW = 12,
    parameter int RD_LAT = 5,
    parameter int WR_LAT = 5
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       psram_sck_i,
    input  logic       psram_ce_i,
    input  logic [7:0] psram_io_in_i,
    output logic [7:0] psram_io_out_o,
    output logic [7:0] psram_io_en_o,
    input  logic       psram_dqs_in_i,
    output logic       psram_dqs_out_o,
    output logic       psram_dqs_en_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_LAT   = 3'd3,
        ST_RDATA = 3'd4,
        ST_WDATA = 3'd5,
        ST_DROP  = 3'd6
    } state_t;

    localparam logic [7:0] CMD_RD  = 8'h00;
    localparam logic [7:0] CMD_WR  = 8'h80;
`ifdef PSRAM_RSP_MR_EN
    localparam logic [7:0] CMD_MRR = 8'h40;
    localparam logic [7:0] CMD_MRW = 8'hC0;
`endif
    // Edge index of the last latency edge; the next edge carries data byte 0.
    localparam logic [7:0] RD_LAST  = 8'(4 + 2 * RD_LAT);
    localparam logic [7:0] WR_LAST  = 8'(4 + 2 * WR_LAT);
    localparam logic [MEM_AW-1:0] ADDR_ONE = MEM_AW'(1);

    // Input staging registers
    logic              sck_d1_q, sck_d2_q, ce_d1_q, dqs_d1_q;
    logic [7:0]        io_d1_q;

    // FSM state and registered outputs
    state_t            state_q;
    logic [7:0]        cnt_q;
    logic [MEM_AW-1:0] addr_q;
    logic              is_wr_q;
    logic              is_mr_q;
    logic [7:0]        io_out_q, io_en_q;
    logic              dqs_out_q, dqs_en_q, busy_q, err_q;

    logic [7:0]        mem_q [2**MEM_AW];

`ifdef PSRAM_RSP_MR_EN
    logic [7:0]        mr_q [8];
    logic              mr_done_q;
`endif

    logic              edge_s;
    logic [7:0]        cnt_inc_s;
    logic [7:0]        lat_last_s;
    logic              mem_we_s;
    logic [7:0]        rd_byte_s;

    // Synchronise the pad inputs into the clk_i domain
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sck_d1_q <= 1'b0;
            sck_d2_q <= 1'b0;
            ce_d1_q  <= 1'b1;
            io_d1_q  <= 8'h00;
            dqs_d1_q <= 1'b0;
        end else begin
            sck_d1_q <= psram_sck_i;
            sck_d2_q <= sck_d1_q;
            ce_d1_q  <= psram_ce_i;
            io_d1_q  <= psram_io_in_i;
            dqs_d1_q <= psram_dqs_in_i;
        end
    end

    // Edge detection, saturating edge count, latency end point and read data select
    always_comb begin
        // A CE rise seen in the same sample as an SCK edge suppresses the edge.
        edge_s = (sck_d1_q != sck_d2_q) && !ce_d1_q;
        if (cnt_q == 8'hFF) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + 8'd1;
        end
        if (is_wr_q) begin
            lat_last_s = WR_LAST;
        end else begin
            lat_last_s = RD_LAST;
        end
        mem_we_s = edge_s && (state_q == ST_WDATA) && !is_mr_q && !dqs_d1_q;
`ifdef PSRAM_RSP_MR_EN
        if (is_mr_q) begin
            rd_byte_s = mr_q[addr_q[2:0]];
        end else begin
            rd_byte_s = mem_q[addr_q];
        end
`else
        rd_byte_s = mem_q[addr_q];
`endif
    end

    // Byte array write port; contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[addr_q] <= io_d1_q;
        end
    end

    // Transaction FSM with registered pin outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            addr_q    <= '0;
            is_wr_q   <= 1'b0;
            is_mr_q   <= 1'b0;
            io_out_q  <= 8'h00;
            io_en_q   <= 8'h00;
            dqs_out_q <= 1'b0;
            dqs_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PSRAM_RSP_MR_EN
            mr_done_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                mr_q[i] <= 8'h00;
            end
`endif
        end else begin
            err_q <= 1'b0;
            if (ce_d1_q) begin
                // Deselect aborts whatever is in flight and releases the bus.
                state_q   <= ST_IDLE;
                io_out_q  <= 8'h00;
                io_en_q   <= 8'h00;
                dqs_out_q <= 1'b0;
                dqs_en_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_CMD;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b1;
                    end
                    ST_CMD: begin
                        if (edge_s) begin
                            cnt_q   <= cnt_inc_s;
                            is_mr_q <= 1'b0;
`ifdef PSRAM_RSP_MR_EN
                            mr_done_q <= 1'b0;
`endif
                            case (io_d1_q)
                                CMD_RD: begin
                                    is_wr_q <= 1'b0;
                                    state_q <= ST_ADDR;
                                end
                                CMD_WR: begin
                                    is_wr_q <= 1'b1;
                                    state_q <= ST_ADDR;
                                end
`ifdef PSRAM_RSP_MR_EN
                                CMD_MRR: begin
                                    is_wr_q <= 1'b0;
                                    is_mr_q <= 1'b1;
                                    state_q <= ST_ADDR;
                                end
                                CMD_MRW: begin
                                    is_wr_q <= 1'b1;
                                    is_mr_q <= 1'b1;
                                    state_q <= ST_ADDR;
                                end
`endif
                                default: begin
                                    err_q   <= 1'b1;
                                    state_q <= ST_DROP;
                                end
                            endcase
                        end
                    end
                    ST_ADDR: begin
                        if (edge_s) begin
                            cnt_q  <= cnt_inc_s;
                            // MSB first; bits above MEM_AW fall off the top.
                            addr_q <= MEM_AW'({addr_q, io_d1_q});
                            if (cnt_q == 8'd4) begin
                                // A zero latency jumps straight to the data phase.
                                if (cnt_q == lat_last_s) begin
                                    state_q <= is_wr_q ? ST_WDATA : ST_RDATA;
                                end else begin
                                    state_q <= ST_LAT;
                                end
                                if (!is_wr_q) begin
                                    dqs_en_q  <= 1'b1;
                                    dqs_out_q <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_LAT: begin
                        if (edge_s) begin
                            cnt_q <= cnt_inc_s;
                            if (cnt_q == lat_last_s) begin
                                state_q <= is_wr_q ? ST_WDATA : ST_RDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (edge_s) begin
                            cnt_q     <= cnt_inc_s;
                            io_out_q  <= rd_byte_s;
                            io_en_q   <= 8'hFF;
                            dqs_out_q <= ~dqs_out_q;
                            // Mode-register reads keep returning the same register.
                            if (!is_mr_q) begin
                                addr_q <= addr_q + ADDR_ONE;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (edge_s) begin
                            cnt_q <= cnt_inc_s;
                            if (!is_mr_q) begin
                                addr_q <= addr_q + ADDR_ONE;
                            end
`ifdef PSRAM_RSP_MR_EN
                            // Only the first data byte of an MR write counts.
                            if (is_mr_q && !mr_done_q) begin
                                if (!dqs_d1_q) begin
                                    mr_q[addr_q[2:0]] <= io_d1_q;
                                end
                                mr_done_q <= 1'b1;
                            end
`endif
                        end
                    end
                    ST_DROP: begin
                        state_q <= ST_DROP;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign psram_io_out_o  = io_out_q;
    assign psram_io_en_o   = io_en_q;
    assign psram_dqs_out_o = dqs_out_q;
    assign psram_dqs_en_o  = dqs_en_q;
    assign busy_o          = busy_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_psram_rsp.sv
// tb_psram_rsp - randomized self-checking bench for psram_rsp.
// Drives the PSRAM pins as a controller would (SCK half period = 4 clk_i) and
// compares read data, strobes, enables and status against a byte-level model
// of the array built from the transactions the bench issued.
module tb_psram_rsp;

    localparam int MEM_AW = 12;
    localparam int RD_LAT = 5;
    localparam int WR_LAT = 5;
    localparam int DEPTH  = 1 << MEM_AW;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       psram_sck_i = 1'b0;
    logic       psram_ce_i = 1'b1;
    logic [7:0] psram_io_in_i = 8'h00;
    logic [7:0] psram_io_out_o;
    logic [7:0] psram_io_en_o;
    logic       psram_dqs_in_i = 1'b0;
    logic       psram_dqs_out_o;
    logic       psram_dqs_en_o;
    logic       busy_o;
    logic       err_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model: bytes written so far, and which addresses are known.
    logic [7:0] mdl_mem   [DEPTH];
    bit         mdl_known [DEPTH];

    // Values sampled 3 clk_i after the latest SCK pin edge
    logic [7:0] smp_io, smp_en;
    logic       smp_dqs, smp_dqsen;

    psram_rsp #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .psram_sck_i    (psram_sck_i),
        .psram_ce_i     (psram_ce_i),
        .psram_io_in_i  (psram_io_in_i),
        .psram_io_out_o (psram_io_out_o),
        .psram_io_en_o  (psram_io_en_o),
        .psram_dqs_in_i (psram_dqs_in_i),
        .psram_dqs_out_o(psram_dqs_out_o),
        .psram_dqs_en_o (psram_dqs_en_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One SCK edge carrying a DQ byte and mask; samples outputs 3 clk_i later.
    task automatic sck_edge(input logic [7:0] d, input logic m);
        psram_io_in_i  = d;
        psram_dqs_in_i = m;
        psram_sck_i    = ~psram_sck_i;
        repeat (3) @(negedge clk_i);
        smp_io    = psram_io_out_o;
        smp_en    = psram_io_en_o;
        smp_dqs   = psram_dqs_out_o;
        smp_dqsen = psram_dqs_en_o;
        @(negedge clk_i);
    endtask

    task automatic begin_txn(input logic [7:0] cmd, input logic [31:0] a);
        psram_ce_i = 1'b0;
        repeat (4) @(negedge clk_i);
        sck_edge(cmd, 1'b0);
        for (int b = 3; b >= 0; b--) begin
            sck_edge(a[8*b +: 8], 1'b0);
        end
    endtask

    task automatic end_txn(input string tag);
        psram_ce_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_eq({tag, "_rel_ioen"}, {24'd0, psram_io_en_o}, 32'd0);
        check_eq({tag, "_rel_dqsen"}, {31'd0, psram_dqs_en_o}, 32'd0);
        check_eq({tag, "_rel_busy"}, {31'd0, busy_o}, 32'd0);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] d[$], input bit m[$], input string tag);
        int p;
        p = int'(a) & (DEPTH - 1);
        begin_txn(8'h80, a);
        for (int i = 0; i < 2 * WR_LAT; i++) sck_edge(8'h00, 1'b0);
        for (int k = 0; k < d.size(); k++) begin
            sck_edge(d[k], m[k]);
            if (!m[k]) begin
                mdl_mem[p]   = d[k];
                mdl_known[p] = 1'b1;
            end
            p = (p + 1) % DEPTH;
        end
        check_eq({tag, "_wr_noen"}, {24'd0, smp_en}, 32'd0);
        end_txn(tag);
    endtask

    task automatic do_read(input logic [31:0] a, input int n, input string tag);
        int p;
        p = int'(a) & (DEPTH - 1);
        begin_txn(8'h00, a);
        for (int i = 0; i < 2 * RD_LAT; i++) sck_edge(8'h00, 1'b0);
        check_eq({tag, "_lat_ioen"}, {24'd0, smp_en}, 32'd0);
        check_eq({tag, "_lat_dqsen"}, {31'd0, smp_dqsen}, 32'd1);
        for (int k = 0; k < n; k++) begin
            sck_edge(8'h00, 1'b0);
            if (mdl_known[p]) begin
                check_eq($sformatf("%s_d%0d", tag, k), {24'd0, smp_io}, {24'd0, mdl_mem[p]});
            end
            check_eq($sformatf("%s_en%0d", tag, k), {24'd0, smp_en}, 32'h0000_00FF);
            check_eq($sformatf("%s_dqs%0d", tag, k), {31'd0, smp_dqs}, (k % 2 == 0) ? 32'd1 : 32'd0);
            p = (p + 1) % DEPTH;
        end
        end_txn(tag);
    endtask

    // Unsupported command: exactly one err_o cycle, no DQ drive, then drop.
    task automatic bad_cmd(input logic [7:0] cmd, input string tag);
        int pulses;
        pulses = 0;
        psram_ce_i = 1'b0;
        repeat (4) @(negedge clk_i);
        psram_io_in_i = cmd;
        psram_sck_i   = ~psram_sck_i;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (err_o) pulses++;
        end
        check_eq({tag, "_err_pulses"}, pulses, 32'd1);
        for (int i = 0; i < 4; i++) sck_edge(8'hFF, 1'b0);
        check_eq({tag, "_noen"}, {24'd0, smp_en}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
        end_txn(tag);
    endtask

    initial begin
        logic [7:0] d[$];
        bit         m[$];
        logic [31:0] ra;
        int          len;

        // Reset with CE high and SCK toggling
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            psram_sck_i = ~psram_sck_i;
        end
        check_eq("rst_io", {24'd0, psram_io_out_o}, 32'd0);
        check_eq("rst_ioen", {24'd0, psram_io_en_o}, 32'd0);
        check_eq("rst_dqs", {30'd0, psram_dqs_out_o, psram_dqs_en_o}, 32'd0);
        check_eq("rst_stat", {30'd0, busy_o, err_o}, 32'd0);
        rst_n_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            psram_sck_i = ~psram_sck_i;
        end
        check_eq("post_rst_stat", {30'd0, busy_o, err_o}, 32'd0);
        check_eq("post_rst_ioen", {24'd0, psram_io_en_o}, 32'd0);

        // Basic write / read
        d = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
        m = '{1'b0, 1'b0, 1'b0, 1'b0};
        do_write(32'h0000_0010, d, m, "wr10");
        do_read(32'h0000_0010, 4, "rd10");

        // Masked write over zeros
        d = '{8'h00, 8'h00, 8'h00, 8'h00};
        do_write(32'h0000_0020, d, m, "clr20");
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        m = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_write(32'h0000_0020, d, m, "mwr20");
        do_read(32'h0000_0020, 4, "rd20");

        // Address wrap at the top of the array
        d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        m = '{1'b0, 1'b0, 1'b0, 1'b0};
        do_write(32'h0000_0FFE, d, m, "wrwrap");
        do_read(32'h0000_0FFE, 4, "rdwrap");
        do_read(32'h0000_0000, 2, "rdlow");

        // Read cut short by CE after 3 bytes, then a normal read
        do_read(32'h0000_0010, 3, "rdcut");
        do_read(32'h0000_0011, 3, "rdafter");

        // Unsupported command
        bad_cmd(8'h55, "cmd55");

`ifdef PSRAM_RSP_MR_EN
        begin_txn(8'hC0, 32'h0000_0003);
        for (int i = 0; i < 2 * WR_LAT; i++) sck_edge(8'h00, 1'b0);
        sck_edge(8'h9E, 1'b0);
        sck_edge(8'h11, 1'b0);
        end_txn("mrw");
        begin_txn(8'h40, 32'h0000_0003);
        for (int i = 0; i < 2 * RD_LAT; i++) sck_edge(8'h00, 1'b0);
        for (int k = 0; k < 2; k++) begin
            sck_edge(8'h00, 1'b0);
            check_eq($sformatf("mrr_d%0d", k), {24'd0, smp_io}, 32'h0000_009E);
        end
        end_txn("mrr");
`else
        bad_cmd(8'h40, "cmd40");
        bad_cmd(8'hC0, "cmdC0");
`endif

        // Randomized writes (full 32-bit address, random masks) with readback
        for (int t = 0; t < 8; t++) begin
            ra  = $urandom;
            len = $urandom_range(1, 6);
            d.delete();
            m.delete();
            for (int k = 0; k < len; k++) begin
                d.push_back(8'($urandom));
                m.push_back($urandom_range(0, 3) == 0);
            end
            do_write(ra, d, m, $sformatf("rwr%0d", t));
            do_read(ra, len, $sformatf("rrd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
